// File: rtl/multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer_if
// Description : Memory handshake bundle between the KGP-miniRISC multi-cycle
//               sequencer (master) and the instruction/data memories (slave).
// Signals     : imem_req   - instruction fetch request     (master -> slave)
//               imem_ready - instruction word valid         (slave  -> master)
//               dmem_req   - data access request            (master -> slave)
//               dmem_ready - data load/store complete       (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output imem_ready,
        output dmem_ready
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_sequencer
// Description : Multi-cycle instruction sequencer for the KGP-miniRISC core.
//               Walks each instruction through FETCH/DECODE/EXEC/MEM/WB and
//               gates the decoder's static controls per phase. Handles memory
//               ready handshakes with timeout, halt, NOP, illegal opcodes and
//               a run/park request.
// Parameters  : MEM_TIMEOUT - max wait cycles for a ready before bus fault
//                             (1..255)
//               CNT_W       - width of the retired-instruction counter
// Ports       : clk, reset  - clock, asynchronous active-high reset
//               run         - 1 = execute, 0 = park at instruction boundary
//               opcode      - IR[31:26], valid from DECODE onward
//               mem         - memory handshake interface (master modport)
//               ir_we       - latch instruction register (Mealy, FETCH)
//               pc_inc      - PC <= PC+4 (Mealy, FETCH)
//               pc_br_we    - branch-class PC update window (EXEC)
//               reg_we      - register file write strobe (WB)
//               illegal_op  - one-cycle pulse on undefined opcode (DECODE)
//               halted      - sticky, core stopped by halt
//               bus_fault   - sticky, memory timeout
//               retired     - retired-instruction count
// Options     : RETIRE_CNT_EN - when defined, builds the retired counter;
//                               otherwise retired is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              run,
    input  wire logic [5:0]        opcode,
    multicycle_sequencer_if.master mem,
    output logic                   ir_we,
    output logic                   pc_inc,
    output logic                   pc_br_we,
    output logic                   reg_we,
    output logic                   illegal_op,
    output logic                   halted,
    output logic                   bus_fault,
    output logic [CNT_W-1:0]       retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    // Wait count value at which one more non-ready cycle means timeout.
    localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait;
    logic       w_wait_last;
    logic       w_boundary;
    logic       w_retire;

    // Opcode class decode (combinational, used in DECODE)
    logic w_op_alu;
    logic w_op_lw;
    logic w_op_sw;
    logic w_op_br;
    logic w_op_bl;
    logic w_op_nop;
    logic w_op_halt;

    // Class captured in DECODE so later phases depend on registered state only
    logic r_is_alu;
    logic r_is_lw;
    logic r_is_sw;
    logic r_is_br;
    logic r_is_bl;

    assign w_op_alu  = (opcode <= 6'h05);
    assign w_op_lw   = (opcode == 6'h06);
    assign w_op_sw   = (opcode == 6'h07);
    assign w_op_br   = (opcode >= 6'h08) && (opcode <= 6'h0E);
    assign w_op_bl   = (opcode == 6'h0F);
    assign w_op_nop  = (opcode == 6'h3E);
    assign w_op_halt = (opcode == 6'h3F);

    assign w_wait_last = (r_wait == C_WAIT_LAST);

    // ------------------------------------------------------------------
    // State register and captured opcode class
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_is_alu <= 1'b0;
            r_is_lw  <= 1'b0;
            r_is_sw  <= 1'b0;
            r_is_br  <= 1'b0;
            r_is_bl  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_is_alu <= w_op_alu;
                r_is_lw  <= w_op_lw;
                r_is_sw  <= w_op_sw;
                r_is_br  <= w_op_br;
                r_is_bl  <= w_op_bl;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wait counter: counts non-ready cycles in FETCH/MEM. It is zero in
    // every other state, so entering a wait state always starts from 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if ((r_state == S_FETCH && !mem.imem_ready) ||
                     (r_state == S_MEM   && !mem.dmem_ready)) begin
            r_wait <= r_wait + 8'd1;
        end else begin
            r_wait <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Next state, Mealy strobes and retire detection
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        ir_we      = 1'b0;
        pc_inc     = 1'b0;
        illegal_op = 1'b0;
        w_boundary = 1'b0;
        w_retire   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem.imem_ready) begin
                    ir_we  = 1'b1;
                    pc_inc = 1'b1;
                    w_next = S_DECODE;
                end else if (w_wait_last) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                if (w_op_alu || w_op_lw || w_op_sw || w_op_br || w_op_bl) begin
                    w_next = S_EXEC;
                end else if (w_op_halt) begin
                    w_next   = S_HALTED;
                    w_retire = 1'b1;
                end else begin
                    // NOP retires silently; anything else is undefined.
                    illegal_op = !w_op_nop;
                    w_boundary = 1'b1;
                end
            end
            S_EXEC: begin
                if (r_is_alu || r_is_bl) begin
                    w_next = S_WB;
                end else if (r_is_lw || r_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_boundary = 1'b1;
                end
            end
            S_MEM: begin
                if (mem.dmem_ready) begin
                    if (r_is_lw) begin
                        w_next = S_WB;
                    end else begin
                        w_boundary = 1'b1;
                    end
                end else if (w_wait_last) begin
                    w_next = S_FAULT;
                end
            end
            S_WB: begin
                w_boundary = 1'b1;
            end
            S_HALTED: begin
                w_next = S_HALTED;
            end
            S_FAULT: begin
                w_next = S_FAULT;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Instruction boundary: continue or park depending on run.
        if (w_boundary) begin
            w_next   = run ? S_FETCH : S_IDLE;
            w_retire = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs decoded from the registered state
    // ------------------------------------------------------------------
    assign mem.imem_req = (r_state == S_FETCH);
    assign mem.dmem_req = (r_state == S_MEM);
    assign pc_br_we     = (r_state == S_EXEC) && (r_is_br || r_is_bl);
    assign reg_we       = (r_state == S_WB);
    assign halted       = (r_state == S_HALTED);
    assign bus_fault    = (r_state == S_FAULT);

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
`ifdef RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;
`else
    logic w_unused_retire;

    assign w_unused_retire = w_retire;
    assign retired         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Self-checking bench for multicycle_sequencer. A table of
//               single-instruction vectors is replayed through a small memory
//               responder, followed by hand-written sequences for halt
//               stickiness, asynchronous reset, run drop during MEM and the
//               retired counter (RETIRE_CNT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [5:0]  opcode;
    logic        ir_we;
    logic        pc_inc;
    logic        pc_br_we;
    logic        reg_we;
    logic        illegal_op;
    logic        halted;
    logic        bus_fault;
    logic [31:0] retired;

    multicycle_sequencer_if mif ();

    multicycle_sequencer #(
        .MEM_TIMEOUT (15),
        .CNT_W       (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode     (opcode),
        .mem        (mif),
        .ir_we      (ir_we),
        .pc_inc     (pc_inc),
        .pc_br_we   (pc_br_we),
        .reg_we     (reg_we),
        .illegal_op (illegal_op),
        .halted     (halted),
        .bus_fault  (bus_fault),
        .retired    (retired)
    );

    always #5 clk = ~clk;

`ifdef RETIRE_CNT_EN
    localparam int C_CNT_ON = 1;
`else
    localparam int C_CNT_ON = 0;
`endif

    typedef struct {
        logic [5:0] op;
        int         iw;      // non-ready fetch cycles before imem_ready
        int         dw;      // non-ready MEM cycles before dmem_ready
        int         len;     // cycles from first imem_req to next fetch/terminal
        int         reg_n;   // reg_we cycles
        int         dmem_n;  // dmem_req cycles
        int         br_n;    // pc_br_we cycles
        int         ill_n;   // illegal_op cycles
        int         ir_n;    // ir_we (and pc_inc) cycles
        bit         halt;
        bit         fault;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         g_iw;
    int         g_dw;
    int         iw_cnt;
    int         dw_cnt;
    logic [5:0] op_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock of memory responder: drive readies after the waits have
    // elapsed, hand out the next opcode with the fetched word, then settle.
    task automatic step();
        @(negedge clk);
        mif.imem_ready = mif.imem_req && (iw_cnt >= g_iw);
        mif.dmem_ready = mif.dmem_req && (dw_cnt >= g_dw);
        if (mif.imem_ready && op_q.size() > 0) begin
            opcode = op_q.pop_front();
        end
        #1;
        if (mif.imem_req && !mif.imem_ready) iw_cnt++;
        else                                 iw_cnt = 0;
        if (mif.dmem_req && !mif.dmem_ready) dw_cnt++;
        else                                 dw_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        run            = 1'b0;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        iw_cnt         = 0;
        dw_cnt         = 0;
        op_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[14];

    initial begin
        int  len, n_reg, n_dmem, n_br, n_ill, n_ir, n_pc, n_imem, stuck;
        bit  started, left, ended;

        //            op     iw   dw  len reg dm br il ir halt fault
        vecs[0]  = '{6'h00, 1,   0,   5, 1, 0, 0, 0, 1, 0, 0};  // add
        vecs[1]  = '{6'h05, 0,   0,   4, 1, 0, 0, 0, 1, 0, 0};  // imm
        vecs[2]  = '{6'h06, 0,   3,   8, 1, 4, 0, 0, 1, 0, 0};  // lw, 3 waits
        vecs[3]  = '{6'h07, 2,   0,   6, 0, 1, 0, 0, 1, 0, 0};  // sw
        vecs[4]  = '{6'h09, 0,   0,   3, 0, 0, 1, 0, 1, 0, 0};  // bz
        vecs[5]  = '{6'h0F, 0,   0,   4, 1, 0, 1, 0, 1, 0, 0};  // bl
        vecs[6]  = '{6'h0E, 0,   0,   3, 0, 0, 1, 0, 1, 0, 0};  // last branch
        vecs[7]  = '{6'h3E, 0,   0,   2, 0, 0, 0, 0, 1, 0, 0};  // nop
        vecs[8]  = '{6'h20, 0,   0,   2, 0, 0, 0, 1, 1, 0, 0};  // illegal
        vecs[9]  = '{6'h10, 1,   0,   3, 0, 0, 0, 1, 1, 0, 0};  // illegal
        vecs[10] = '{6'h3F, 0,   0,   2, 0, 0, 0, 0, 1, 1, 0};  // halt
        vecs[11] = '{6'h06, 0, 255,  18, 0,15, 0, 0, 1, 0, 1};  // lw timeout
        vecs[12] = '{6'h06, 0,  14,  19, 1,15, 0, 0, 1, 0, 0};  // ready on 15th
        vecs[13] = '{6'h00, 255, 0,  15, 0, 0, 0, 0, 0, 0, 1};  // fetch timeout

        reset          = 1'b1;
        run            = 1'b0;
        opcode         = 6'h00;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        g_iw           = 0;
        g_dw           = 0;
        iw_cnt         = 0;
        dw_cnt         = 0;

        // Reset state
        #2;
        chk("reset_outputs",
            {mif.imem_req, mif.dmem_req, ir_we, pc_inc, pc_br_we, reg_we,
             illegal_op, halted, bus_fault}, 0);
        chk("reset_retired", retired, 0);

        // Table-driven single-instruction vectors
        for (int v = 0; v < 14; v++) begin
            do_reset();
            g_iw = vecs[v].iw;
            g_dw = vecs[v].dw;
            op_q.push_back(vecs[v].op);
            run = 1'b1;
            started = 0; left = 0; ended = 0;
            len = 0; n_reg = 0; n_dmem = 0; n_br = 0; n_ill = 0; n_ir = 0; n_pc = 0;
            for (int c = 0; c < 60 && !ended; c++) begin
                step();
                if (halted || bus_fault) begin
                    ended = 1;
                end else if (mif.imem_req && started && left) begin
                    ended = 1;
                end else begin
                    if (mif.imem_req) started = 1;
                    else if (started) left = 1;
                    if (started) begin
                        len++;
                        n_reg  += int'(reg_we);
                        n_dmem += int'(mif.dmem_req);
                        n_br   += int'(pc_br_we);
                        n_ill  += int'(illegal_op);
                        n_ir   += int'(ir_we);
                        n_pc   += int'(pc_inc);
                    end
                end
            end
            chk($sformatf("v%0d_ended", v), ended, 1);
            chk($sformatf("v%0d_len", v), len, vecs[v].len);
            chk($sformatf("v%0d_reg_we", v), n_reg, vecs[v].reg_n);
            chk($sformatf("v%0d_dmem_req", v), n_dmem, vecs[v].dmem_n);
            chk($sformatf("v%0d_pc_br_we", v), n_br, vecs[v].br_n);
            chk($sformatf("v%0d_illegal_op", v), n_ill, vecs[v].ill_n);
            chk($sformatf("v%0d_ir_we", v), n_ir, vecs[v].ir_n);
            chk($sformatf("v%0d_pc_inc", v), n_pc, vecs[v].ir_n);
            chk($sformatf("v%0d_halted", v), halted, vecs[v].halt);
            chk($sformatf("v%0d_bus_fault", v), bus_fault, vecs[v].fault);
            chk($sformatf("v%0d_retired", v), retired,
                (C_CNT_ON != 0 && !vecs[v].fault) ? 1 : 0);
        end

        // Halt is sticky under run=1; asynchronous reset clears it mid-cycle
        do_reset();
        g_iw = 0; g_dw = 0;
        op_q.push_back(6'h3F);
        run = 1'b1;
        for (int c = 0; c < 20 && !halted; c++) step();
        chk("halt_reached", halted, 1);
        stuck = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (halted && !mif.imem_req && !mif.dmem_req && !bus_fault) stuck++;
        end
        chk("halt_sticky_cycles", stuck, 10);
        chk("halt_retired", retired, C_CNT_ON);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_halted", halted, 0);
        chk("async_reset_retired", retired, 0);
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b0;

        // run dropped in MEM of lw: lw still writes back, then parks in IDLE
        do_reset();
        g_iw = 0; g_dw = 3;
        op_q.push_back(6'h06);
        run = 1'b1;
        for (int c = 0; c < 20 && !mif.dmem_req; c++) step();
        chk("rundrop_in_mem", mif.dmem_req, 1);
        run = 1'b0;
        n_reg = 0; n_dmem = 0; n_imem = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            n_reg  += int'(reg_we);
            n_dmem += int'(mif.dmem_req);
            n_imem += int'(mif.imem_req);
        end
        chk("rundrop_reg_we", n_reg, 1);
        chk("rundrop_dmem_rest", n_dmem, 3);
        chk("rundrop_parked_no_fetch", n_imem, 0);

        // Three instructions back to back, then park; retired count
        do_reset();
        g_iw = 0; g_dw = 0;
        op_q.push_back(6'h00);
        op_q.push_back(6'h3E);
        op_q.push_back(6'h07);
        run = 1'b1;
        for (int c = 0; c < 30 && !mif.dmem_req; c++) step();
        chk("three_sw_mem", mif.dmem_req, 1);
        run = 1'b0;
        n_imem = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            n_imem += int'(mif.imem_req);
        end
        chk("three_parked", n_imem, 0);
        chk("three_retired", retired, 3 * C_CNT_ON);
        do_reset();
        chk("three_retired_after_reset", retired, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
